func_ci_ctrl: RTL
=================

# func_ci_ctrl

Multi-cycle custom-instruction front end that sits directly upstream of the `func` accumulator. It decodes the CPU's custom-instruction handshake into `func` jobs: launch, blocking run, collect and status. It tracks job state and elapsed cycles and latches the `func` result. It also guards `func` against illegal launches: launch while busy, and `size == 0`, which would otherwise hang `func`.

## Interface

Parameters:
- `TIMEOUT_CYCLES`, default 1000000: busy-cycle count after which a waiting CI is released with `NAN_ERR`.
- `NAN_ERR`, default 32'h7FC00000: result returned on timeout.
- `BUSY_ERR`, default 32'hFFFFFFFF: result returned when a launch is refused.

Ports:
- `clk`  in  1  system clock.
- `reset`  in  1  synchronous reset, active-low.
- `clk_en`  in  1  CPU CI clock enable; the CI side ignores `ci_start` when low.
- `ci_start`  in  1  CI request strobe, one cycle.
- `ci_n`  in  2  opcode: 0 RUN, 1 LAUNCH, 2 COLLECT, 3 STATUS.
- `ci_dataa`  in  32  base pointer (RUN/LAUNCH).
- `ci_datab`  in  32  element count (RUN/LAUNCH).
- `ci_done`  out  1  response strobe, one cycle.
- `ci_result`  out  32  response data, valid while `ci_done` is high.
- `func_start`  out  1  job launch pulse to `func`.
- `func_base_ptr`  out  32  held from launch until the next launch.
- `func_size`  out  32  held from launch until the next launch.
- `func_done`  in  1  one-cycle completion pulse from `func`.
- `func_result`  in  32  FP32 sum, valid with `func_done`.

## Operation

- **State:**
  - FSM states: IDLE, START, WAIT_JOB, RESP.
  - Job flags: `busy`, `timeout` (sticky), `refused` (sticky).
  - Registers: `cycles` (29-bit, saturating) and `last_result`.
- **IDLE.** On `ci_start & clk_en`, decode `ci_n`:
  - RUN: if `busy`, set `refused` and go to RESP with `BUSY_ERR`. If `ci_datab == 0`, go to RESP with 32'h00000000; do not start `func`. Otherwise capture the pointers, clear `timeout`/`refused`/`cycles`, set `busy`, go to START with `blocking = 1`.
  - LAUNCH: same checks as RUN, with `blocking = 0`.
  - COLLECT: if `busy`, go to WAIT_JOB. Otherwise go to RESP with `last_result`.
  - STATUS: go to RESP with `{busy, timeout, refused, cycles[28:0]}`.
- **START.** Drive `func_start = 1` for this one cycle. If `blocking`, go to WAIT_JOB; otherwise go to RESP with 0.
- **WAIT_JOB.**
  - On `func_done`: go to RESP with `func_result`.
  - Else if `cycles == TIMEOUT_CYCLES`: set `timeout` and go to RESP with `NAN_ERR`. The job stays `busy`.
- **RESP.** `ci_done = 1` and `ci_result` = selected value for one cycle, then return to IDLE.
- **Job tracking** runs independently of the FSM and regardless of `clk_en`:
  - While `busy`, `cycles` increments and saturates at all-ones.
  - `func_done` always clears `busy` and loads `last_result`, so a completion during any FSM state is never lost.
- `ci_start` arriving outside IDLE is ignored; the CPU protocol forbids it.

## Timing

- **Reset** (`reset == 0` at a `clk` edge) forces:
  - `ci_done`, `ci_result`, `func_start`, `func_base_ptr`, `func_size` to 0.
  - State to IDLE.
  - `busy`, `timeout`, `refused`, `cycles`, `last_result` to 0.
- **Reset mid-job** abandons the job. A later `func_done` still loads `last_result` but does not set `busy`.
- **Latencies** (`ci_start` at edge 0):
  - STATUS, refused launch, `size == 0`, and COLLECT with no job running: `ci_done` at edge 1.
  - LAUNCH: `func_start` at edge 1, `ci_done` at edge 2.
  - RUN: `func_start` at edge 1. If `func_done` arrives at edge k, `ci_done` is at edge k+1.
- **Simultaneous events:**
  - `func_done` in the same cycle as a LAUNCH decode: `busy` is cleared first, then the launch is accepted.
  - `func_done` coincident with timeout detection: `func_done` wins and the result is returned.
- `func_start` never pulses while `busy` was set before the decode.

## Test plan

- **RUN:** base 0x1000, size 4; `func_done` at edge 60 with 0x41200000 → `func_start` at edge 1, `ci_done` at edge 61 with 0x41200000, STATUS then reads busy=0.
- **LAUNCH / STATUS / COLLECT:** LAUNCH size 8 → `ci_done` at edge 2 with 0. STATUS while running → bit31=1. COLLECT before `func_done` → waits and returns `func_result` one cycle after `func_done`.
- **Refused launch:** LAUNCH while busy → `BUSY_ERR`, no `func_start`, STATUS bit29=1.
- **Empty job:** RUN with size 0 → `ci_done` at edge 1 with 0x00000000, `func_start` never asserted.
- **Timeout:** `TIMEOUT_CYCLES` = 20, `func_done` withheld → RUN returns 0x7FC00000, STATUS bits31:30 = 11. A later `func_done` clears busy, and COLLECT returns its value.
- **Reset mid-job:** pull `reset` low during WAIT_JOB → all outputs 0, state IDLE. After release, STATUS returns 0.

Source files
------------

// File: rtl/func_ci_ctrl.sv
// Custom-instruction front end for the func accumulator.
// Decodes CI opcodes into func jobs and tracks job status.
module func_ci_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 1000000,
  parameter logic [31:0] NAN_ERR        = 32'h7FC00000,
  parameter logic [31:0] BUSY_ERR       = 32'hFFFFFFFF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clk_en,
  input  logic        ci_start,
  input  logic [1:0]  ci_n,
  input  logic [31:0] ci_dataa,
  input  logic [31:0] ci_datab,
  output logic        ci_done,
  output logic [31:0] ci_result,
  output logic        func_start,
  output logic [31:0] func_base_ptr,
  output logic [31:0] func_size,
  input  logic        func_done,
  input  logic [31:0] func_result
);

  typedef enum logic [1:0] {
    IDLE,
    START,
    WAIT_JOB,
    RESP
  } state_t;

  localparam logic [28:0] TO_LIM = 29'(TIMEOUT_CYCLES);

  state_t      state_q, state_d;
  logic [31:0] res_q, res_d;
  logic [31:0] base_q, base_d;
  logic [31:0] size_q, size_d;
  logic        blk_q, blk_d;

  logic        busy_q, to_q, ref_q;
  logic [28:0] cyc_q;
  logic [31:0] last_q;

  logic        accept, set_ref, set_to;
  logic        busy_eff;

  // A completion in the decode cycle frees the job slot first
  assign busy_eff = busy_q & ~func_done;

  always_comb begin
    state_d = state_q;
    res_d   = res_q;
    base_d  = base_q;
    size_d  = size_q;
    blk_d   = blk_q;
    accept  = 1'b0;
    set_ref = 1'b0;
    set_to  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (ci_start && clk_en) begin
          unique case (ci_n)
            2'd0, 2'd1: begin
              if (busy_eff) begin
                set_ref = 1'b1;
                res_d   = BUSY_ERR;
                state_d = RESP;
              end else if (ci_datab == 32'd0) begin
                res_d   = 32'd0;
                state_d = RESP;
              end else begin
                accept  = 1'b1;
                base_d  = ci_dataa;
                size_d  = ci_datab;
                blk_d   = (ci_n == 2'd0);
                state_d = START;
              end
            end
            2'd2: begin
              if (busy_eff) begin
                state_d = WAIT_JOB;
              end else begin
                res_d   = func_done ? func_result : last_q;
                state_d = RESP;
              end
            end
            2'd3: begin
              res_d   = {busy_q, to_q, ref_q, cyc_q};
              state_d = RESP;
            end
          endcase
        end
      end
      START: begin
        if (blk_q) begin
          state_d = WAIT_JOB;
        end else begin
          res_d   = 32'd0;
          state_d = RESP;
        end
      end
      WAIT_JOB: begin
        if (func_done) begin
          res_d   = func_result;
          state_d = RESP;
        end else if (cyc_q == TO_LIM) begin
          set_to  = 1'b1;
          res_d   = NAN_ERR;
          state_d = RESP;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      res_q   <= '0;
      base_q  <= '0;
      size_q  <= '0;
      blk_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      res_q   <= res_d;
      base_q  <= base_d;
      size_q  <= size_d;
      blk_q   <= blk_d;
    end
  end

  // Job tracking is independent of the CI handshake
  always_ff @(posedge clk) begin
    if (!reset) begin
      busy_q <= 1'b0;
      to_q   <= 1'b0;
      ref_q  <= 1'b0;
      cyc_q  <= '0;
      last_q <= '0;
    end else begin
      if (busy_q && (cyc_q != '1)) begin
        cyc_q <= cyc_q + 29'd1;
      end
      if (func_done) begin
        busy_q <= 1'b0;
        last_q <= func_result;
      end
      if (accept) begin
        busy_q <= 1'b1;
        cyc_q  <= '0;
        to_q   <= 1'b0;
        ref_q  <= 1'b0;
      end
      if (set_ref) begin
        ref_q <= 1'b1;
      end
      if (set_to) begin
        to_q <= 1'b1;
      end
    end
  end

  assign ci_done       = (state_q == RESP);
  assign ci_result     = ci_done ? res_q : 32'd0;
  assign func_start    = (state_q == START);
  assign func_base_ptr = base_q;
  assign func_size     = size_q;

endmodule
